// File: rtl/lms_ctr_switch_pkg.sv
// Shared constants and helpers for the switch debounce front end.
package lms_ctr_switch_pkg;

    localparam int SW_WIDTH                = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int CLK_HZ                  = 50_000_000;

    // Width of a counter that must reach DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lms_ctr_debounce_bit.sv
// One switch bit: 2-FF synchroniser, hold-time debounce counter,
// registered stable level and single-cycle rise/fall pulses.
module lms_ctr_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after it has held CNT_MAX+1 samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cnt       <= '0;
            sw_stable <= 1'b0;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            if (sync_p1 == sw_stable) begin
                // Input agrees with the accepted level: any partial count is a glitch.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                sw_stable <= sync_p1;
                sw_rise   <= sync_p1;
                sw_fall   <= ~sync_p1;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lms_ctr_switch_debounce.sv
// Switch/push-button conditioning ahead of the lms_ctr_switch PIO.
// Build option: define LMS_CTR_SWITCH_EDGE_CAPTURE_EN to get sticky rise
// flags (edge_capture, write-one-to-clear) and a registered irq; otherwise
// both outputs are tied low and edge_clear is ignored.
module lms_ctr_switch_debounce
    import lms_ctr_switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        lms_ctr_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i])
        );
    end

`ifdef LMS_CTR_SWITCH_EDGE_CAPTURE_EN
    // Sticky rise flags; a new rise beats a simultaneous clear so no edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | sw_rise;
        end
    end

    // Interrupt follows the flags one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |edge_capture;
        end
    end
`else
    logic unused_edge_clear;

    assign unused_edge_clear = ^edge_clear;
    assign edge_capture      = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: doc/lms_ctr_switch_debounce.md
Name: lms_ctr_switch_debounce

Overview:
- Front-end conditioning stage for the board DIP switches / push-buttons.
- Sits directly upstream of the lms_ctr_switch Avalon PIO input; sw_stable drives that PIO's in_port.
- Per bit: 2-FF synchroniser, then counter-based debounce, then registered stable value plus single-cycle rise/fall pulses.
- Optional sticky edge-capture with interrupt for the NIOS control CPU.

Parameters:
- WIDTH, 8, number of switch bits (matches PIO in_port width).
- DEBOUNCE_CYCLES, 50000, cycles the synchronised input must hold a new value before acceptance (1 ms at 50 MHz); legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic in this single domain.
- reset  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  asynchronous raw switch pins.
- sw_stable  out  WIDTH  debounced level; to lms_ctr_switch in_port.
- sw_rise  out  WIDTH  one-cycle pulse per bit on accepted 0->1.
- sw_fall  out  WIDTH  one-cycle pulse per bit on accepted 1->0.
- edge_clear  in  WIDTH  write-one-to-clear strobe for edge_capture.
- edge_capture  out  WIDTH  sticky rise flags (feature-dependent).
- irq  out  1  OR of edge_capture (feature-dependent).

Behaviour:
- Interface decided: one clock, clk; reset is synchronous and active-high, port reset.
- Reset (sampled at posedge clk while reset=1) clears sync stages, counters, sw_stable, sw_rise, sw_fall and edge_capture. irq=0.
- Sync: s1<=sw_raw; s2<=s1. No other logic touches sw_raw.
- Per bit, each cycle:
  - If s2==sw_stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: sw_stable<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
- Latency: if sw_raw changes before edge t and holds, sw_stable updates at edge t+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=1 the block is a pure 3-cycle synchroniser.
- Glitch rejection: any return of s2 to sw_stable before the count completes resets cnt to 0. No output change.
- Counter never wraps; max value is DEBOUNCE_CYCLES-1.
- sw_rise/sw_fall are registered and asserted in the same cycle sw_stable takes its new value, for exactly one cycle. Never both set on one bit.
- Bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.
- Reset mid-count abandons the count. If sw_raw=1 is held through reset release, sw_stable rises 1+DEBOUNCE_CYCLES edges after the first non-reset edge, with a sw_rise pulse.

Optional Feature:
- Macro: LMS_CTR_SWITCH_EDGE_CAPTURE_EN.
- Defined:
  - edge_capture[i] is set on sw_rise[i].
  - Cleared by edge_clear[i]=1.
  - Set and clear in the same cycle: set wins.
  - irq is registered, = |edge_capture, one cycle behind.
- Undefined: edge_capture and irq are tied 0 and edge_clear is ignored. Ports remain present so the integration stays unchanged.

Decomposition:
- Package lms_ctr_switch_pkg: SW_WIDTH=8 default, DEBOUNCE_CYCLES_DEFAULT=50000, CLK_HZ constant, clog2-based counter width helper.
- Sub-module lms_ctr_debounce_bit: one bit of sync + counter + stable + pulse, instantiated WIDTH times via generate.
- Top level holds only the edge-capture/irq logic.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset, then sw_raw=8'h00 held 20 cycles -> sw_stable=0x00, no pulses, irq=0.
- sw_raw=8'h01 from edge t, held -> sw_stable=0x01 at edge t+5, sw_rise=0x01 for exactly 1 cycle, sw_fall=0.
- Bit 2 pulsed high for 3 cycles then low -> sw_stable unchanged, no pulses. Repeat with 6 cycles -> accepted, rise and later fall pulse.
- sw_raw=8'hA5 while reset asserted, reset released at edge r -> sw_stable=0xA5 at edge r+5 with sw_rise=0xA5. Assert reset mid-count -> outputs return to 0.
- With LMS_CTR_SWITCH_EDGE_CAPTURE_EN: rise on bit 3 -> edge_capture=0x08, irq=1 next cycle. edge_clear=0x08 coincident with a new rise on bit 3 -> stays 0x08. edge_clear=0x08 alone -> 0x00, irq drops next cycle.
- Without macro: same stimulus -> edge_capture=0x00, irq=0 throughout. DEBOUNCE_CYCLES=1 build: 3-cycle latency check.
